// File: rtl/prim_fifo_burst_reader_pkg.sv
// Shared types and helpers for the FIFO burst reader.
//   state_e        : reader FSM state encoding (IDLE / FILL / SEND)
//   lane_cnt_width : width of a counter that can hold 0..ratio packed lanes
package prim_fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    // Counter must reach the value ratio itself (the "full" count), hence ratio+1.
    function automatic int unsigned lane_cnt_width(input int unsigned ratio);
        return (ratio < 32'd2) ? 32'd1 : $clog2(ratio + 32'd1);
    endfunction

endpackage

// File: rtl/prim_lane_packer.sv
// Packs narrow words into a wide beat, lane 0 first.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write data_i into the next free lane (ignored when full)
//   data_i        : narrow word to pack
//   clear_i       : zero all lanes, mask and count (wins over push_i)
//   full_o        : all Ratio lanes written
//   data_o        : packed lanes, lane 0 in the LSBs; unwritten lanes are zero
//   mask_o        : per-lane written flags, contiguous from lane 0
module prim_lane_packer
    import prim_fifo_burst_reader_pkg::*;
#(
    parameter int unsigned Width = 16,
    parameter int unsigned Ratio = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     clear_i,
    output logic                     full_o,
    output logic [Width*Ratio-1:0]   data_o,
    output logic [Ratio-1:0]         mask_o
);

    localparam int unsigned CntW = lane_cnt_width(Ratio);

    logic [Ratio-1:0][Width-1:0] lanes_r;
    logic [Ratio-1:0]            mask_r;
    logic [CntW-1:0]             cnt_r;
    logic                        full_s;

    assign full_s = (cnt_r == CntW'(Ratio));

    // Lane storage: clear has priority, otherwise append one word at cnt_r.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lanes_r <= '0;
            mask_r  <= '0;
            cnt_r   <= '0;
        end else if (clear_i) begin
            lanes_r <= '0;
            mask_r  <= '0;
            cnt_r   <= '0;
        end else if (push_i && !full_s) begin
            for (int i = 0; i < int'(Ratio); i++) begin
                if (cnt_r == CntW'(i)) begin
                    lanes_r[i] <= data_i;
                    mask_r[i]  <= 1'b1;
                end
            end
            cnt_r <= cnt_r + CntW'(1);
        end
    end

    assign full_o = full_s;
    assign data_o = lanes_r;
    assign mask_o = mask_r;

endmodule

// File: rtl/prim_fifo_burst_reader.sv
// Read-side burst consumer for the FIFO read interface. Waits for the FIFO
// to reach a watermark (or an idle timeout), pops up to Ratio words, and
// emits them as one wide beat. Partial beats leave on FILL timeout or flush.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   fifo_rvalid_i/fifo_rready_o/fifo_rdata_i/fifo_rdepth_i : FIFO read port
//   watermark_i       : occupancy needed before a burst starts
//   timeout_i         : idle/partial timeout in cycles, 0 disables
//   flush_i           : push out a partially packed beat
//   out_valid_o/out_ready_i/out_data_o/out_mask_o : wide output beat
// Optional build macro PRIM_FIFO_BURST_READER_STATS_EN adds stat_beats_o and
// stat_partial_o (saturating counts of accepted beats / partial beats).
module prim_fifo_burst_reader
    import prim_fifo_burst_reader_pkg::*;
#(
    parameter int unsigned Width    = 16,
    parameter int unsigned Depth    = 4,
    parameter int unsigned DepthW   = $clog2(Depth + 1),
    parameter int unsigned Ratio    = 2,
    parameter int unsigned TimeoutW = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fifo_rvalid_i,
    output logic                    fifo_rready_o,
    input  logic [Width-1:0]        fifo_rdata_i,
    input  logic [DepthW-1:0]       fifo_rdepth_i,
    input  logic [DepthW-1:0]       watermark_i,
    input  logic [TimeoutW-1:0]     timeout_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [Width*Ratio-1:0]  out_data_o,
    output logic [Ratio-1:0]        out_mask_o
`ifdef PRIM_FIFO_BURST_READER_STATS_EN
    ,
    output logic [31:0]             stat_beats_o,
    output logic [31:0]             stat_partial_o
`endif
);

    state_e               state_r, state_next_s;
    logic [TimeoutW-1:0]  timer_r, timer_next_s;
    logic                 rready_r, rready_next_s;
    logic                 valid_r, valid_next_s;

    logic                 pop_s, accept_s, depth_ok_s, tmo_hit_s;
    logic                 any_s, will_full_s, full_s;
    logic [Ratio-1:0]     mask_s;
    logic [TimeoutW-1:0]  timer_inc_s;

    assign pop_s       = fifo_rvalid_i && rready_r;
    assign accept_s    = (state_r == ST_SEND) && out_ready_i;
    assign depth_ok_s  = (fifo_rdepth_i >= watermark_i);
    assign tmo_hit_s   = (timeout_i != {TimeoutW{1'b0}}) && (timer_r == timeout_i);
    assign any_s       = mask_s[0];
    // Mask is contiguous, so "one lane short of full" is lane Ratio-2 set, Ratio-1 clear.
    assign will_full_s = pop_s && mask_s[Ratio-2] && !mask_s[Ratio-1];
    assign timer_inc_s = (timer_r == {TimeoutW{1'b1}}) ? timer_r : timer_r + TimeoutW'(1);

    prim_lane_packer #(
        .Width (Width),
        .Ratio (Ratio)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pop_s),
        .data_i  (fifo_rdata_i),
        .clear_i (accept_s),
        .full_o  (full_s),
        .data_o  (out_data_o),
        .mask_o  (mask_s)
    );

    // State, timer and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            timer_r  <= {TimeoutW{1'b0}};
            rready_r <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            timer_r  <= timer_next_s;
            rready_r <= rready_next_s;
            valid_r  <= valid_next_s;
        end
    end

    // Next-state logic. In FILL a pop is folded in before flush/timeout decisions.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fifo_rvalid_i && (depth_ok_s || tmo_hit_s)) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (full_s || will_full_s) begin
                    state_next_s = ST_SEND;
                end else if (flush_i && (any_s || pop_s)) begin
                    state_next_s = ST_SEND;
                end else if (flush_i) begin
                    state_next_s = ST_IDLE;
                end else if (!pop_s && any_s && tmo_hit_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_SEND: begin
                if (!out_ready_i) begin
                    state_next_s = ST_SEND;
                end else if (fifo_rvalid_i && depth_ok_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Timer: counts starved cycles in IDLE and pop-less cycles of a partial beat in FILL.
    always_comb begin
        timer_next_s = {TimeoutW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if ((state_next_s == ST_IDLE) && fifo_rvalid_i && !depth_ok_s) begin
                    timer_next_s = timer_inc_s;
                end else begin
                    timer_next_s = {TimeoutW{1'b0}};
                end
            end
            ST_FILL: begin
                if ((state_next_s == ST_FILL) && !pop_s && any_s) begin
                    timer_next_s = timer_inc_s;
                end else begin
                    timer_next_s = {TimeoutW{1'b0}};
                end
            end
            default: begin
                timer_next_s = {TimeoutW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops.
    always_comb begin
        rready_next_s = (state_next_s == ST_FILL);
        valid_next_s  = (state_next_s == ST_SEND);
    end

    assign fifo_rready_o = rready_r;
    assign out_valid_o   = valid_r;
    assign out_mask_o    = mask_s;

`ifdef PRIM_FIFO_BURST_READER_STATS_EN
    logic [31:0] stat_beats_r, stat_partial_r;

    // Saturating counters of accepted beats and accepted partial beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_beats_r   <= 32'd0;
            stat_partial_r <= 32'd0;
        end else if (accept_s) begin
            if (stat_beats_r != 32'hFFFF_FFFF) begin
                stat_beats_r <= stat_beats_r + 32'd1;
            end
            if (!(&mask_s) && (stat_partial_r != 32'hFFFF_FFFF)) begin
                stat_partial_r <= stat_partial_r + 32'd1;
            end
        end
    end

    assign stat_beats_o   = stat_beats_r;
    assign stat_partial_o = stat_partial_r;
`endif

endmodule

// File: tb/tb_prim_fifo_burst_reader.sv
module tb_prim_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fifo_rvalid = 1'b0;
    logic        fifo_rready;
    logic [15:0] fifo_rdata = 16'h0;
    logic [2:0]  fifo_rdepth = 3'd0;
    logic [2:0]  watermark = 3'd2;
    logic [7:0]  timeout = 8'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_mask;
`ifdef PRIM_FIFO_BURST_READER_STATS_EN
    logic [31:0] stat_beats, stat_partial;
`endif

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [15:0] q[$];

    prim_fifo_burst_reader #(
        .Width(16), .Depth(4), .DepthW(3), .Ratio(2), .TimeoutW(8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .fifo_rvalid_i (fifo_rvalid),
        .fifo_rready_o (fifo_rready),
        .fifo_rdata_i  (fifo_rdata),
        .fifo_rdepth_i (fifo_rdepth),
        .watermark_i   (watermark),
        .timeout_i     (timeout),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_mask_o    (out_mask)
`ifdef PRIM_FIFO_BURST_READER_STATS_EN
        ,
        .stat_beats_o  (stat_beats),
        .stat_partial_o(stat_partial)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_fifo();
        fifo_rvalid = (q.size() != 0);
        fifo_rdata  = (q.size() != 0) ? q[0] : 16'h0;
        fifo_rdepth = 3'(q.size());
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        drive_fifo();
    endtask

    // One clock: the FIFO model pops if the handshake was set up before the edge.
    task automatic step();
        logic p;
        p = fifo_rvalid && fifo_rready;
        @(posedge clk);
        #1;
        if (p) begin
            pops++;
            void'(q.pop_front());
        end
        drive_fifo();
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait: out_valid got %b expected 1 within %0d cycles", nm, out_valid, budget);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        out_ready = 1'b0;
        flush = 1'b0;
        q.delete();
        drive_fifo();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (fifo_rready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_mask !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: got rready=%b valid=%b data=%h mask=%b expected 0 0 00000000 00",
                     fifo_rready, out_valid, out_data, out_mask);
        end
        step();
        rst_ni = 1'b1;
        step();
        checks++;
        if (fifo_rready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rready=%b valid=%b expected 0 0", fifo_rready, out_valid);
        end
    endtask

    task automatic test_full_beat();
        int p0 = pops;
        watermark = 3'd2;
        timeout = 8'd0;
        push(16'h1111);
        push(16'h2222);
        wait_valid(10, "full_beat");
        checks++;
        if (out_data !== 32'h2222_1111) begin
            errors++;
            $display("FAIL full_data: got %h expected %h", out_data, 32'h2222_1111);
        end
        checks++;
        if (out_mask !== 2'b11) begin
            errors++;
            $display("FAIL full_mask: got %b expected 11", out_mask);
        end
        checks++;
        if (pops - p0 != 2) begin
            errors++;
            $display("FAIL full_pops: got %0d expected 2", pops - p0);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || fifo_rready !== 1'b0) begin
            errors++;
            $display("FAIL full_to_idle: got valid=%b rready=%b expected 0 0", out_valid, fifo_rready);
        end
    endtask

    task automatic test_timeout();
        watermark = 3'd3;
        timeout = 8'd4;
        push(16'hABCD);
        repeat (4) step();
        checks++;
        if (fifo_rready !== 1'b0) begin
            errors++;
            $display("FAIL idle_timer_hold: rready got %b expected 0", fifo_rready);
        end
        step();
        checks++;
        if (fifo_rready !== 1'b1) begin
            errors++;
            $display("FAIL idle_timer_expire: rready got %b expected 1", fifo_rready);
        end
        wait_valid(20, "fill_timeout");
        checks++;
        if (out_data !== 32'h0000_ABCD || out_mask !== 2'b01) begin
            errors++;
            $display("FAIL fill_timeout_beat: got data=%h mask=%b expected 0000abcd 01", out_data, out_mask);
        end
        accept();
    endtask

    task automatic test_flush();
        watermark = 3'd1;
        timeout = 8'd0;
        push(16'h0005);
        repeat (4) step();
        checks++;
        if (out_valid !== 1'b0 || fifo_rready !== 1'b1) begin
            errors++;
            $display("FAIL flush_prewait: got valid=%b rready=%b expected 0 1", out_valid, fifo_rready);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 2'b01 || out_data !== 32'h0000_0005) begin
            errors++;
            $display("FAIL flush_beat: got valid=%b mask=%b data=%h expected 1 01 00000005",
                     out_valid, out_mask, out_data);
        end
        accept();
    endtask

    task automatic test_watermark_stall();
        int p0;
        watermark = 3'd3;
        timeout = 8'd0;
        p0 = pops;
        push(16'h0101);
        push(16'h0202);
        repeat (6) step();
        checks++;
        if (fifo_rready !== 1'b0 || pops != p0) begin
            errors++;
            $display("FAIL wm_stall: got rready=%b pops=%0d expected 0 %0d", fifo_rready, pops, p0);
        end
        push(16'h0303);
        wait_valid(10, "wm_reach");
        checks++;
        if (out_data !== 32'h0202_0101) begin
            errors++;
            $display("FAIL wm_data: got %h expected %h", out_data, 32'h0202_0101);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || fifo_rready !== 1'b0) begin
            errors++;
            $display("FAIL wm_below_after_send: got valid=%b rready=%b expected 0 0", out_valid, fifo_rready);
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        int p0;
        watermark = 3'd2;
        timeout = 8'd0;
        push(16'h00A1);
        push(16'h00A2);
        push(16'h00A3);
        push(16'h00A4);
        wait_valid(10, "bp_first");
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_data !== 32'h00A2_00A1 || out_mask !== 2'b11 || fifo_rready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got data=%h mask=%b rready=%b valid=%b expected 00a200a1 11 0 1",
                         i, out_data, out_mask, fifo_rready, out_valid);
            end
        end
        checks++;
        if (pops != p0) begin
            errors++;
            $display("FAIL bp_no_pop: got %0d pops expected %0d", pops, p0);
        end
        accept();
        checks++;
        if (fifo_rready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_fill: got rready=%b valid=%b expected 1 0", fifo_rready, out_valid);
        end
        wait_valid(10, "bp_second");
        checks++;
        if (out_data !== 32'h00A4_00A3) begin
            errors++;
            $display("FAIL bp_second_data: got %h expected %h", out_data, 32'h00A4_00A3);
        end
        accept();
    endtask

    task automatic test_reset_mid();
        watermark = 3'd1;
        timeout = 8'd0;
        push(16'h0077);
        step();
        step();
        checks++;
        if (out_data !== 32'h0000_0077 || fifo_rready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got data=%h rready=%b expected 00000077 1", out_data, fifo_rready);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (fifo_rready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_mask !== 2'b00) begin
            errors++;
            $display("FAIL midrst_async: got rready=%b valid=%b data=%h mask=%b expected 0 0 00000000 00",
                     fifo_rready, out_valid, out_data, out_mask);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        watermark = 3'd2;
        push(16'h1234);
        push(16'h5678);
        wait_valid(10, "midrst_after");
        checks++;
        if (out_data !== 32'h5678_1234 || out_mask !== 2'b11) begin
            errors++;
            $display("FAIL midrst_packer_empty: got data=%h mask=%b expected 56781234 11", out_data, out_mask);
        end
        accept();
    endtask

`ifdef PRIM_FIFO_BURST_READER_STATS_EN
    task automatic test_stats();
        apply_reset();
        watermark = 3'd2;
        timeout = 8'd0;
        for (int i = 0; i < 3; i++) begin
            push(16'(i));
            push(16'(i + 16));
            wait_valid(10, "stats_full");
            accept();
        end
        watermark = 3'd1;
        push(16'h00EE);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_valid(10, "stats_partial");
        accept();
        checks++;
        if (stat_beats !== 32'd4 || stat_partial !== 32'd1) begin
            errors++;
            $display("FAIL stats: got beats=%0d partial=%0d expected 4 1", stat_beats, stat_partial);
        end
    endtask
`endif

    initial begin
        drive_fifo();
        test_reset();
        test_full_beat();
        test_timeout();
        test_flush();
        test_watermark_stall();
        test_backpressure();
        test_reset_mid();
`ifdef PRIM_FIFO_BURST_READER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prim_fifo_burst_reader.md
Name: prim_fifo_burst_reader

Overview:
Read-side consumer for the team's FIFO read interface (rvalid/rready/rdata/rdepth). It waits until the FIFO holds enough entries, pops them, and packs Ratio words into one wide output beat. Partial beats are flushed on timeout or on request. It sits in the destination clock domain, directly behind an async FIFO's read port, and feeds wide-datapath consumers.

Parameters:
Width, 16, FIFO word width
Depth, 4, depth of the upstream FIFO; sizes the depth/watermark ports
DepthW, $clog2(Depth+1), width of the depth/watermark fields
Ratio, 2, FIFO words per output beat (>=2)
TimeoutW, 8, width of the timeout counter and threshold

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
fifo_rvalid_i  in  1  FIFO has data
fifo_rready_o  out  1  pop request; a pop occurs when fifo_rvalid_i & fifo_rready_o
fifo_rdata_i  in  Width  FIFO head word
fifo_rdepth_i  in  DepthW  FIFO occupancy
watermark_i  in  DepthW  minimum occupancy before a burst starts
timeout_i  in  TimeoutW  idle/partial timeout in cycles; 0 disables
flush_i  in  1  force out any partially packed beat
out_valid_o  out  1  wide beat valid
out_ready_i  in  1  downstream accept
out_data_o  out  Width*Ratio  packed data; first popped word in lane 0 (LSBs)
out_mask_o  out  Ratio  per-lane valid; always contiguous from lane 0

Behaviour:
- One clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: fifo_rready_o=0, out_valid_o=0, out_data_o=0, out_mask_o=0, state=IDLE, lane count=0, timer=0.
- FSM states IDLE, FILL, SEND.
- IDLE: fifo_rready_o=0. Go to FILL when fifo_rvalid_i and either:
  - fifo_rdepth_i >= watermark_i (watermark 0 or 1 means immediately), or
  - the IDLE timer reaches timeout_i (timeout_i != 0).
- IDLE timer: increments each cycle with fifo_rvalid_i && depth < watermark. It clears when rvalid drops or on leaving IDLE.
- FILL: fifo_rready_o=1. Each pop writes fifo_rdata_i into lane[cnt], sets mask[cnt], and increments cnt.
  - The pop making cnt==Ratio moves to SEND on the same edge.
  - FILL timer: clears on every pop; increments on cycles without a pop while cnt>=1. At timer==timeout_i (nonzero), go to SEND with a partial mask.
  - flush_i with cnt>=1: go to SEND with a partial mask. Any pop in that same cycle is included first.
  - flush_i with cnt==0: return to IDLE.
- SEND: fifo_rready_o=0 and out_valid_o=1. out_data_o and out_mask_o stay stable until out_ready_i.
  - On accept: lanes are zeroed, cnt=0, mask=0.
  - Next state is FILL if fifo_rvalid_i && depth >= watermark, else IDLE.
  - out_valid_o is never withdrawn without an accept. flush_i is ignored in SEND.
- Unused lanes of a partial beat read as zero.
- Throughput: at most one beat per Ratio+1 cycles. There is no pop during SEND.
- Comparisons are unsigned at DepthW width. A watermark above Depth can only start via timeout; with timeout_i=0 in that case, the block stalls in IDLE. This is legal and documented.
- Reset mid-operation discards packed words; popped words are lost. Reset is expected to be coordinated with the FIFO reset.

Optional Feature:
PRIM_FIFO_BURST_READER_STATS_EN
- Defined: adds outputs stat_beats_o [31:0] and stat_partial_o [31:0].
  - stat_beats_o counts accepted beats; stat_partial_o counts accepted beats with mask != all-ones.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package prim_fifo_burst_reader_pkg: state enum typedef (IDLE/FILL/SEND, 2-bit) and lane-index width function.
- One sub-module, prim_lane_packer:
  - holds the Ratio lane registers, mask and count;
  - inputs are push, data and clear; outputs are full, data and mask.
- The FSM and timers remain in the top module.

Test Plan:
- Width=16, Ratio=2, watermark=2, timeout=0. FIFO holds 0x1111, 0x2222 (depth 2) -> one beat out_data=0x22221111, mask=2'b11, two pops, then IDLE.
- watermark=3, timeout=4, one word 0xABCD, depth 1 -> stays IDLE 4 cycles, enters FILL, pops, FILL timer expires after 4 idle cycles -> out_data=0x0000ABCD, mask=2'b01.
- Mid-FILL with cnt=1 (0x0005), assert flush_i -> next cycle out_valid=1, mask=2'b01, data=0x00000005.
- Hold out_ready_i=0 for 10 cycles in SEND with FIFO depth 4 -> out_data/mask stable, fifo_rready_o=0, no pops; on accept, next burst proceeds.
- Assert rst_ni low during FILL with cnt=1 -> all outputs 0 asynchronously; after release, state IDLE with an empty packer.
- Stats build: 3 full beats plus 1 partial -> stat_beats=4, stat_partial=1.
